// File: rtl/store_buffer.sv
// Write buffer between the MEM-stage load/store port and data_mem: stores are absorbed in one
// cycle and drained while the CPU port is idle; loads bypass to data_mem with store forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpu_address,
  input  logic [31:0]      cpu_write_data,
  input  logic             cpu_mem_read,
  input  logic             cpu_mem_write,
  output logic [31:0]      cpu_read_data,
  output logic             stall,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_read_data
);

  logic [15:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  logic             load;
  logic             full;
  logic             drain;
  logic             enq;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] idx;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == (PTR_W+1)'(DEPTH));
  assign load  = cpu_mem_read;

  // A load always owns the port; a pending store only forces a drain when the buffer is full.
  assign drain = !rst && !empty && !cpu_mem_read && (!cpu_mem_write || full);
  assign enq   = !rst && cpu_mem_write && !cpu_mem_read && !full;
  assign stall = !rst && cpu_mem_write && !cpu_mem_read && full;

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (load) begin
      mem_address = cpu_address;
      mem_read    = 1'b1;
    end else if (drain) begin
      mem_address    = {16'b0, addr_q[head]};
      mem_write_data = data_q[head];
      mem_write      = 1'b1;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt) && (addr_q[idx] == cpu_address[15:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign cpu_read_data = !load ? 32'b0 : (fwd_hit ? fwd_data : mem_read_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      cnt <= cnt + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= cpu_address[15:0];
      data_q[tail] <= cpu_write_data;
    end
  end

endmodule
